// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Sits between decode and fetch for RISC-V conditional branches. A decoded
//   branch is accepted over valid/ready. Its operands and comparison-select code
//   go to an external ComparisonUnit, and after COMP_LATENCY cycles the result
//   bit is turned into taken/target for fetch. Only one branch is in flight.
//   Optional feature: define BRU_STATS_EN to build the taken / not-taken /
//   illegal handshake counters. Without it the stat_* ports are tied to zero.
//   Illegal funct3 (010/011) never consults the comparator. It spends one cycle
//   in WAIT so that it answers with the same one-cycle accept-to-valid timing
//   as a zero-latency compare.

module branch_resolve_unit #(
  parameter int dataWidth    = 32,
  parameter int selectWidth  = 4,
  parameter int COMP_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_funct3,
  input  logic [dataWidth-1:0]   in_rs1,
  input  logic [dataWidth-1:0]   in_rs2,
  input  logic [dataWidth-1:0]   in_pc,
  input  logic [dataWidth-1:0]   in_imm,
  output logic [dataWidth-1:0]   comp_a,
  output logic [dataWidth-1:0]   comp_b,
  output logic [selectWidth-1:0] comp_sel,
  input  logic [dataWidth-1:0]   comp_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_taken,
  output logic [dataWidth-1:0]   out_target,
  output logic                   out_illegal,
  output logic                   out_misalign,
  output logic [31:0]            stat_taken,
  output logic [31:0]            stat_not_taken,
  output logic [31:0]            stat_illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } stateT;

  localparam int cntWidth = (COMP_LATENCY < 1) ? 1 : $clog2(COMP_LATENCY + 1);
  localparam logic [cntWidth-1:0] latencyLoad = cntWidth'(COMP_LATENCY);

  stateT                  state;
  stateT                  nextState;
  logic                   idleReg;
  logic                   accept;
  logic                   outFire;
  logic                   resolveNow;
  logic                   legalReq;
  logic [selectWidth-1:0] reqSel;
  logic [dataWidth-1:0]   pcReg;
  logic [dataWidth-1:0]   immReg;
  logic [dataWidth-1:0]   takenTarget;
  logic [dataWidth-1:0]   fallTarget;
  logic                   illegalReg;
  logic [cntWidth-1:0]    waitCnt;
  logic                   compTaken;
  logic                   unusedCompBits;

  // funct3 values 010 and 011 are not conditional branches
  function automatic logic isLegal(input logic [2:0] f3);
    return !((f3 == 3'b010) || (f3 == 3'b011));
  endfunction

  // Map B-type funct3 onto the ComparisonUnit select codes
  function automatic logic [selectWidth-1:0] encodeSelect(input logic [2:0] f3);
    logic [selectWidth-1:0] sel;
    case (f3)
      3'b000:  sel = selectWidth'(0);
      3'b001:  sel = selectWidth'(1);
      3'b100:  sel = selectWidth'(2);
      3'b110:  sel = selectWidth'(3);
      3'b101:  sel = selectWidth'(8);
      3'b111:  sel = selectWidth'(9);
      default: sel = selectWidth'(0);
    endcase
    return sel;
  endfunction

  assign legalReq       = isLegal(in_funct3);
  assign reqSel         = encodeSelect(in_funct3);
  assign in_ready       = idleReg && !flush;
  assign accept         = in_valid && in_ready;
  assign out_valid      = (state == RESP);
  assign outFire        = out_valid && out_ready;
  assign resolveNow     = (state == WAIT) && (waitCnt == '0) && !flush;
  assign compTaken      = comp_result[0];
  assign unusedCompBits = ^comp_result[dataWidth-1:1];
  assign takenTarget    = pcReg + immReg;
  assign fallTarget     = pcReg + dataWidth'(4);

  // State register; idleReg keeps in_ready low while reset is held
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      idleReg <= 1'b0;
    end else begin
      state   <= nextState;
      idleReg <= (nextState == IDLE);
    end
  end

  // Next-state selection; flush always wins and returns to IDLE
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (accept) nextState = WAIT;
      WAIT: if (waitCnt == '0) nextState = RESP;
      RESP: if (outFire) nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (flush) nextState = IDLE;
  end

  // Capture the branch context that is needed to build the target later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcReg      <= '0;
      immReg     <= '0;
      illegalReg <= 1'b0;
    end else if (accept) begin
      pcReg      <= in_pc;
      immReg     <= in_imm;
      illegalReg <= !legalReq;
    end
  end

  // Comparator inputs only change on a legal accept so the ComparisonUnit sees no glitches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      comp_a   <= '0;
      comp_b   <= '0;
      comp_sel <= '0;
    end else if (accept && legalReq) begin
      comp_a   <= in_rs1;
      comp_b   <= in_rs2;
      comp_sel <= reqSel;
    end
  end

  // Countdown of comparator latency; illegal branches start at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCnt <= '0;
    end else if (accept) begin
      waitCnt <= legalReq ? latencyLoad : '0;
    end else if ((state == WAIT) && (waitCnt != '0)) begin
      waitCnt <= waitCnt - 1'b1;
    end
  end

  // Latch the resolution once the comparator result is valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_taken    <= 1'b0;
      out_target   <= '0;
      out_illegal  <= 1'b0;
      out_misalign <= 1'b0;
    end else if (resolveNow) begin
      if (illegalReg) begin
        out_taken    <= 1'b0;
        out_target   <= fallTarget;
        out_illegal  <= 1'b1;
        out_misalign <= 1'b0;
      end else begin
        out_taken    <= compTaken;
        out_target   <= compTaken ? takenTarget : fallTarget;
        out_illegal  <= 1'b0;
        out_misalign <= compTaken && (takenTarget[1:0] != 2'b00);
      end
    end
  end

`ifdef BRU_STATS_EN
  logic [31:0] statTakenReg;
  logic [31:0] statNotTakenReg;
  logic [31:0] statIllegalReg;

  // Count each completed out handshake by class; flushed branches never get here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      statTakenReg    <= '0;
      statNotTakenReg <= '0;
      statIllegalReg  <= '0;
    end else if (outFire) begin
      if (out_illegal) begin
        statIllegalReg <= statIllegalReg + 32'd1;
      end else if (out_taken) begin
        statTakenReg <= statTakenReg + 32'd1;
      end else begin
        statNotTakenReg <= statNotTakenReg + 32'd1;
      end
    end
  end

  assign stat_taken     = statTakenReg;
  assign stat_not_taken = statNotTakenReg;
  assign stat_illegal   = statIllegalReg;
`else
  assign stat_taken     = 32'd0;
  assign stat_not_taken = 32'd0;
  assign stat_illegal   = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit
//   Directed plus random branches against a behavioural model of RISC-V branch
//   resolution. The ComparisonUnit is stood in for by a one-cycle registered
//   comparator that also drives garbage on the unused upper result bits.

module tb_branch_resolve_unit;

  localparam int dataWidth   = 32;
  localparam int selectWidth = 4;
  localparam int compLatency = 1;
`ifdef BRU_STATS_EN
  localparam bit statsBuilt = 1'b1;
`else
  localparam bit statsBuilt = 1'b0;
`endif

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic        illegal;
    logic        misalign;
    logic [3:0]  sel;
  } expT;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [2:0]  inFunct3;
  logic [31:0] inRs1;
  logic [31:0] inRs2;
  logic [31:0] inPc;
  logic [31:0] inImm;
  logic [31:0] compA;
  logic [31:0] compB;
  logic [3:0]  compSel;
  logic [31:0] compResult = 32'd0;
  logic        outValid;
  logic        outReady;
  logic        outTaken;
  logic [31:0] outTarget;
  logic        outIllegal;
  logic        outMisalign;
  logic [31:0] statTaken;
  logic [31:0] statNotTaken;
  logic [31:0] statIllegal;

  int compareCount = 0;
  int failCount    = 0;
  int expTakenCnt    = 0;
  int expNotTakenCnt = 0;
  int expIllegalCnt  = 0;

  branch_resolve_unit #(
    .dataWidth(dataWidth),
    .selectWidth(selectWidth),
    .COMP_LATENCY(compLatency)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(inValid),
    .in_ready(inReady),
    .in_funct3(inFunct3),
    .in_rs1(inRs1),
    .in_rs2(inRs2),
    .in_pc(inPc),
    .in_imm(inImm),
    .comp_a(compA),
    .comp_b(compB),
    .comp_sel(compSel),
    .comp_result(compResult),
    .out_valid(outValid),
    .out_ready(outReady),
    .out_taken(outTaken),
    .out_target(outTarget),
    .out_illegal(outIllegal),
    .out_misalign(outMisalign),
    .stat_taken(statTaken),
    .stat_not_taken(statNotTaken),
    .stat_illegal(statIllegal)
  );

  always #5 clk = ~clk;

  // Stand-in ComparisonUnit with one cycle of latency
  function automatic logic standInCompare(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
    case (sel)
      4'd0:    return a == b;
      4'd1:    return a != b;
      4'd2:    return $signed(a) < $signed(b);
      4'd3:    return a < b;
      4'd8:    return $signed(a) >= $signed(b);
      4'd9:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    compResult <= {31'($urandom()), standInCompare(compA, compB, compSel)};
  end

  // Reference: what the ISA says a conditional branch does
  function automatic expT refBranch(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                                    input logic [31:0] pc, input logic [31:0] imm);
    expT e;
    logic [31:0] jump;
    e.illegal = 1'b0;
    e.taken   = 1'b0;
    e.sel     = 4'd0;
    case (f3)
      3'b000: begin e.taken = (rs1 == rs2);                 e.sel = 4'd0; end
      3'b001: begin e.taken = (rs1 != rs2);                 e.sel = 4'd1; end
      3'b100: begin e.taken = ($signed(rs1) <  $signed(rs2)); e.sel = 4'd2; end
      3'b110: begin e.taken = (rs1 <  rs2);                 e.sel = 4'd3; end
      3'b101: begin e.taken = ($signed(rs1) >= $signed(rs2)); e.sel = 4'd8; end
      3'b111: begin e.taken = (rs1 >= rs2);                 e.sel = 4'd9; end
      default: e.illegal = 1'b1;
    endcase
    jump       = pc + imm;
    e.target   = e.taken ? jump : pc + 32'd4;
    e.misalign = e.taken && (jump % 4 != 0);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkStats(input string tag);
    checkOutput({tag, ".statTaken"},    statTaken,    statsBuilt ? 32'(expTakenCnt)    : 32'd0);
    checkOutput({tag, ".statNotTaken"}, statNotTaken, statsBuilt ? 32'(expNotTakenCnt) : 32'd0);
    checkOutput({tag, ".statIllegal"},  statIllegal,  statsBuilt ? 32'(expIllegalCnt)  : 32'd0);
  endtask

  task automatic countHandshake(input expT e);
    if (e.illegal)    expIllegalCnt++;
    else if (e.taken) expTakenCnt++;
    else              expNotTakenCnt++;
  endtask

  // Issue one branch, wait for its resolution, check it, optionally complete the handshake
  task automatic applyStimulus(input string tag, input logic [2:0] f3, input logic [31:0] rs1,
                               input logic [31:0] rs2, input logic [31:0] pc, input logic [31:0] imm,
                               input int readyDelay, input bit doHandshake);
    expT e;
    int  lat;
    e = refBranch(f3, rs1, rs2, pc, imm);
    @(negedge clk);
    inValid  = 1'b1;
    inFunct3 = f3;
    inRs1    = rs1;
    inRs2    = rs2;
    inPc     = pc;
    inImm    = imm;
    checkOutput({tag, ".inReady"}, inReady, 1);
    @(negedge clk);
    inValid = 1'b0;
    inRs1   = $urandom();
    inPc    = $urandom();
    if (!e.illegal) begin
      checkOutput({tag, ".compSel"}, compSel, e.sel);
      checkOutput({tag, ".compA"},   compA,   rs1);
      checkOutput({tag, ".compB"},   compB,   rs2);
    end
    lat = 0;
    while (!outValid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, ".latency"},    lat,         e.illegal ? 1 : compLatency + 1);
    checkOutput({tag, ".outTaken"},   outTaken,    e.taken);
    checkOutput({tag, ".outTarget"},  outTarget,   e.target);
    checkOutput({tag, ".outIllegal"}, outIllegal,  e.illegal);
    checkOutput({tag, ".outMisalign"}, outMisalign, e.misalign);
    for (int i = 0; i < readyDelay; i++) begin
      @(negedge clk);
      checkOutput({tag, ".hold.outValid"},  outValid,  1);
      checkOutput({tag, ".hold.outTarget"}, outTarget, e.target);
      checkOutput({tag, ".hold.outTaken"},  outTaken,  e.taken);
      checkOutput({tag, ".hold.inReady"},   inReady,   0);
    end
    if (doHandshake) begin
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;
      countHandshake(e);
      checkOutput({tag, ".post.outValid"}, outValid, 0);
      checkOutput({tag, ".post.inReady"},  inReady,  1);
      checkStats({tag, ".post"});
    end
  endtask

  // Bound on total run time
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    expT         lastExp;
    logic [2:0]  rf3;
    logic [31:0] rr1, rr2, rpc, rimm;

    reset    = 1'b1;
    flush    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    inFunct3 = 3'b000;
    inRs1    = '0;
    inRs2    = '0;
    inPc     = '0;
    inImm    = '0;

    // Reset state
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset.inReady",    inReady,     0);
    checkOutput("reset.outValid",   outValid,    0);
    checkOutput("reset.outTaken",   outTaken,    0);
    checkOutput("reset.outTarget",  outTarget,   0);
    checkOutput("reset.outIllegal", outIllegal,  0);
    checkOutput("reset.compSel",    compSel,     0);
    checkOutput("reset.compA",      compA,       0);
    checkStats("reset");
    reset = 1'b1;
    @(negedge clk);
    checkOutput("release.inReady", inReady, 1);

    // Directed branches from the ISA semantics
    applyStimulus("beq",   3'b000, 32'd8,         32'd8, 32'h100,      32'h20, 0, 1);
    applyStimulus("blt",   3'b100, 32'h80000009,  32'd7, 32'h300,      32'h40, 0, 1);
    applyStimulus("bltu",  3'b110, 32'h80000009,  32'd7, 32'h300,      32'h40, 0, 1);
    applyStimulus("bge",   3'b101, 32'd7,         32'd7, 32'h400,      32'hFFFFFFF0, 0, 1);
    applyStimulus("bgeu",  3'b111, 32'd7,         32'd7, 32'h400,      32'h8, 0, 1);
    applyStimulus("bne",   3'b001, 32'd7,         32'd7, 32'h500,      32'h8, 0, 1);
    applyStimulus("ill010", 3'b010, 32'd1,        32'd1, 32'h200,      32'h40, 0, 1);
    applyStimulus("ill011", 3'b011, 32'd3,        32'd9, 32'h600,      32'h40, 0, 1);
    applyStimulus("wrap",  3'b000, 32'd1,         32'd1, 32'hFFFFFFF0, 32'h20, 0, 1);
    applyStimulus("misal", 3'b000, 32'd1,         32'd1, 32'hFFFFFFF0, 32'h22, 0, 1);

    // Backpressure: out_ready low for five cycles
    applyStimulus("stall", 3'b100, 32'hFFFFFFFE,  32'd3, 32'h800,      32'h10, 5, 1);

    // Flush while waiting on the comparator drops the branch
    @(negedge clk);
    inValid  = 1'b1;
    inFunct3 = 3'b000;
    inRs1    = 32'd5;
    inRs2    = 32'd5;
    inPc     = 32'h700;
    inImm    = 32'h8;
    @(negedge clk);
    inValid = 1'b0;
    flush   = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("flushWait.outValid", outValid, 0);
      @(negedge clk);
    end
    checkOutput("flushWait.inReady", inReady, 1);
    checkStats("flushWait");

    // Flush with a request pending in IDLE: nothing is accepted
    inValid  = 1'b1;
    inFunct3 = 3'b001;
    flush    = 1'b1;
    #1;
    checkOutput("flushIdle.inReady", inReady, 0);
    @(negedge clk);
    inValid = 1'b0;
    flush   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("flushIdle.outValid", outValid, 0);
    end

    // Flush coinciding with the out handshake still counts the branch
    applyStimulus("flushHs", 3'b110, 32'd2, 32'd9, 32'h900, 32'h30, 0, 0);
    lastExp  = refBranch(3'b110, 32'd2, 32'd9, 32'h900, 32'h30);
    outReady = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    flush    = 1'b0;
    countHandshake(lastExp);
    checkOutput("flushHs.outValid", outValid, 0);
    checkStats("flushHs");

    // Random branches with random backpressure
    for (int n = 0; n < 40; n++) begin
      rf3  = 3'($urandom_range(0, 7));
      rr1  = $urandom();
      rr2  = ($urandom_range(0, 3) == 0) ? rr1 : $urandom();
      rpc  = $urandom() & 32'hFFFFFFFC;
      rimm = 32'($urandom_range(0, 8190)) - 32'd4096;
      rimm[0] = 1'b0;
      applyStimulus($sformatf("rnd%0d", n), rf3, rr1, rr2, rpc, rimm, $urandom_range(0, 3), 1);
    end

    // Asynchronous reset while a response is pending
    applyStimulus("preRst", 3'b101, 32'd9, 32'd2, 32'h1000, 32'h44, 0, 0);
    #2 reset = 1'b0;
    #1;
    checkOutput("asyncRst.outValid",  outValid,  0);
    checkOutput("asyncRst.outTaken",  outTaken,  0);
    checkOutput("asyncRst.outTarget", outTarget, 0);
    checkOutput("asyncRst.compA",     compA,     0);
    checkOutput("asyncRst.compSel",   compSel,   0);
    checkOutput("asyncRst.inReady",   inReady,   0);
    expTakenCnt    = 0;
    expNotTakenCnt = 0;
    expIllegalCnt  = 0;
    checkStats("asyncRst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("asyncRst.release.inReady", inReady, 1);
    applyStimulus("afterRst", 3'b000, 32'd4, 32'd4, 32'h40, 32'h10, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
